inst_fetch_unit: RTL and testbench

INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

---
 rtl/inst_fetch_pkg.sv | 15 +
 rtl/ifu_fifo.sv | 59 +++++
 rtl/inst_fetch_unit.sv | 111 +++++++++++
 tb/tb_inst_fetch_unit.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared state encoding, default widths and halt opcode for the instruction fetch unit.
package inst_fetch_pkg;
    localparam int DEFAULT_ADDR_W     = 64;
    localparam int DEFAULT_INST_W     = 32;
    localparam int DEFAULT_FIFO_DEPTH = 4;

    localparam logic [31:0] HALT_OPCODE = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_RESET,
        ST_FETCH,
        ST_DRAIN,
        ST_HALT
    } ifu_state_e;
endpackage

// File: rtl/ifu_fifo.sv
// Synchronous fetch buffer holding {pc, inst} entries with push, pop, clear and occupancy count.
module ifu_fifo
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int WIDTH = DEFAULT_ADDR_W + DEFAULT_INST_W
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_clear,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_rdata,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Clear wins over a same-cycle pop so a redirect always leaves the buffer empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (i_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (i_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push && !i_clear) mem_q[wr_ptr_q] <= i_wdata;
    end

    assign o_rdata = mem_q[rd_ptr_q];
    assign o_count = count_q;
endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: issues sequential fetches, buffers responses, handles redirects.
// Optional end-of-program detection is enabled with the IFU_HALT_DETECT_EN macro.
module inst_fetch_unit
    import inst_fetch_pkg::*;
#(
    parameter int                ADDR_W     = DEFAULT_ADDR_W,
    parameter int                INST_W     = DEFAULT_INST_W,
    parameter int                FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic              o_imem_valid,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_valid,
    input  logic [INST_W-1:0] i_imem_inst,
    output logic              o_inst_valid,
    output logic [INST_W-1:0] o_inst,
    output logic [ADDR_W-1:0] o_inst_pc,
    input  logic              i_inst_ready,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    output logic              o_halted
);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int DATA_W = ADDR_W + INST_W;

    ifu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              req_q, req_d;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W-1:0] fifo_rdata;
    logic              issue, resp_ok, halt_hit, push, pop, inst_valid;

    // Memory answers exactly one cycle later, so a single flag tracks the outstanding request;
    // a response landing in a redirect cycle or outside FETCH is dropped.
    always_comb begin
        issue    = (state_q == ST_FETCH) && !i_redirect
                   && ((fifo_count + CNT_W'(req_q)) < CNT_W'(FIFO_DEPTH));
        resp_ok  = i_imem_valid && req_q && (state_q == ST_FETCH) && !i_redirect;
`ifdef IFU_HALT_DETECT_EN
        halt_hit = resp_ok && (i_imem_inst == INST_W'(HALT_OPCODE));
`else
        halt_hit = 1'b0;
`endif
        push       = resp_ok && !halt_hit;
        inst_valid = (fifo_count != '0);
        pop        = inst_valid && i_inst_ready;
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_d    = issue;
        req_pc_d = req_pc_q;
        if (issue) begin
            pc_d     = pc_q + ADDR_W'(4);
            req_pc_d = pc_q;
        end
        case (state_q)
            ST_RESET: state_d = ST_FETCH;
            ST_FETCH: if (halt_hit) state_d = ST_DRAIN;
            ST_DRAIN: if (!inst_valid && !req_q) state_d = ST_HALT;
            default:  state_d = state_q;
        endcase
        if (i_redirect) begin
            state_d = ST_FETCH;
            pc_d    = i_redirect_pc;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_RESET;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            req_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            req_q    <= req_d;
        end
    end

    ifu_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_pop   (pop),
        .i_clear (i_redirect),
        .i_wdata ({req_pc_q, i_imem_inst}),
        .o_rdata (fifo_rdata),
        .o_count (fifo_count)
    );

    assign o_imem_valid = issue;
    assign o_imem_addr  = pc_q;
    assign o_inst_valid = inst_valid;
    assign o_inst       = inst_valid ? fifo_rdata[INST_W-1:0] : '0;
    assign o_inst_pc    = inst_valid ? fifo_rdata[DATA_W-1:INST_W] : '0;
`ifdef IFU_HALT_DETECT_EN
    assign o_halted     = (state_q == ST_HALT);
`else
    assign o_halted     = 1'b0;
`endif
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed self-checking bench for inst_fetch_unit with a one-cycle-latency memory model.
module tb_inst_fetch_unit;
    localparam int          ADDR_W     = 64;
    localparam int          INST_W     = 32;
    localparam int          FIFO_DEPTH = 4;
    localparam logic [63:0] RESET_PC   = 64'h0;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic              o_imem_valid;
    logic [ADDR_W-1:0] o_imem_addr;
    logic              i_imem_valid = 1'b0;
    logic [INST_W-1:0] i_imem_inst = '0;
    logic              o_inst_valid;
    logic [INST_W-1:0] o_inst;
    logic [ADDR_W-1:0] o_inst_pc;
    logic              i_inst_ready = 1'b0;
    logic              i_redirect = 1'b0;
    logic [ADDR_W-1:0] i_redirect_pc = '0;
    logic              o_halted;

    int checks = 0;
    int errors = 0;

    logic              halt_mode = 1'b0;
    logic              cap_valid = 1'b0;
    logic [ADDR_W-1:0] cap_addr = '0;
    logic [ADDR_W-1:0] req_log [$];

    inst_fetch_unit #(
        .ADDR_W     (ADDR_W),
        .INST_W     (INST_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .RESET_PC   (RESET_PC)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .o_imem_valid  (o_imem_valid),
        .o_imem_addr   (o_imem_addr),
        .i_imem_valid  (i_imem_valid),
        .i_imem_inst   (i_imem_inst),
        .o_inst_valid  (o_inst_valid),
        .o_inst        (o_inst),
        .o_inst_pc     (o_inst_pc),
        .i_inst_ready  (i_inst_ready),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_halted      (o_halted)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] mem_inst(input logic [63:0] a);
        if (halt_mode && a == 64'h10) return 32'hFFFF_FFFF;
        return 32'hC0DE_0000 | {16'h0, a[15:0]};
    endfunction

    // Requests are sampled just before the rising edge; the answer is driven just after it.
    always @(negedge i_clk) begin
        #4;
        cap_valid = o_imem_valid;
        cap_addr  = o_imem_addr;
        if (o_imem_valid) req_log.push_back(o_imem_addr);
    end

    always @(posedge i_clk) begin
        #1;
        i_imem_valid = cap_valid;
        i_imem_inst  = cap_valid ? mem_inst(cap_addr) : '0;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic do_reset();
        @(negedge i_clk);
        i_rst_n       = 1'b0;
        i_inst_ready  = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = '0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        req_log.delete();
    endtask

    task automatic test_reset();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_imem_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL rst_imem_valid got %b want 0", o_imem_valid);
        end
        checks++;
        if (o_inst_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL rst_inst_valid got %b want 0", o_inst_valid);
        end
        checks++;
        if (o_inst !== '0 || o_inst_pc !== '0) begin
            errors++; $display("[TB] FAIL rst_inst got %h/%h want 0/0", o_inst, o_inst_pc);
        end
        checks++;
        if (o_halted !== 1'b0 || o_imem_addr !== RESET_PC) begin
            errors++; $display("[TB] FAIL rst_halt_addr got %b/%h want 0/%h", o_halted, o_imem_addr, RESET_PC);
        end
        do_reset();
    endtask

    task automatic test_sequential();
        logic [63:0] e;
        do_reset();
        i_inst_ready = 1'b1;
        #1;
        checks++;
        if (o_imem_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL seq_c0_noreq got %b want 0", o_imem_valid);
        end
        for (int c = 1; c <= 3; c++) begin
            @(negedge i_clk); #1;
            e = 64'(4 * (c - 1));
            checks++;
            if (o_imem_valid !== 1'b1 || o_imem_addr !== e) begin
                errors++; $display("[TB] FAIL seq_req_c%0d got %b/%h want 1/%h", c, o_imem_valid, o_imem_addr, e);
            end
            if (c == 2) begin
                checks++;
                if (o_inst_valid !== 1'b0) begin
                    errors++; $display("[TB] FAIL seq_c2_novalid got %b want 0", o_inst_valid);
                end
            end
        end
        checks++;
        if (o_inst_valid !== 1'b1 || o_inst_pc !== 64'h0 || o_inst !== mem_inst(64'h0)) begin
            errors++; $display("[TB] FAIL seq_c3_first got %b/%h/%h want 1/0/%h", o_inst_valid, o_inst_pc, o_inst, mem_inst(64'h0));
        end
        for (int k = 1; k <= 6; k++) begin
            @(negedge i_clk); #1;
            e = 64'(4 * k);
            checks++;
            if (o_inst_valid !== 1'b1 || o_inst_pc !== e || o_inst !== mem_inst(e)) begin
                errors++; $display("[TB] FAIL seq_stream_%0d got %b/%h/%h want 1/%h/%h", k, o_inst_valid, o_inst_pc, o_inst, e, mem_inst(e));
            end
            checks++;
            if (o_imem_valid !== 1'b1 || o_imem_addr !== e + 64'h8) begin
                errors++; $display("[TB] FAIL seq_issue_%0d got %b/%h want 1/%h", k, o_imem_valid, o_imem_addr, e + 64'h8);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] e;
        int n;
        do_reset();
        for (int c = 1; c <= 11; c++) begin
            @(negedge i_clk); #1;
            if (c >= 3) begin
                checks++;
                if (o_inst_valid !== 1'b1 || o_inst_pc !== 64'h0 || o_inst !== mem_inst(64'h0)) begin
                    errors++; $display("[TB] FAIL bp_stable_c%0d got %b/%h/%h want 1/0/%h", c, o_inst_valid, o_inst_pc, o_inst, mem_inst(64'h0));
                end
            end
        end
        checks++;
        if (req_log.size() != FIFO_DEPTH) begin
            errors++; $display("[TB] FAIL bp_req_count got %0d want %0d", req_log.size(), FIFO_DEPTH);
        end
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (req_log.size() > i) begin
                checks++;
                if (req_log[i] !== 64'(4 * i)) begin
                    errors++; $display("[TB] FAIL bp_req_addr_%0d got %h want %h", i, req_log[i], 64'(4 * i));
                end
            end
        end
        e = 64'h0;
        n = 0;
        for (int c = 0; c < 40 && n < 8; c++) begin
            @(negedge i_clk);
            i_inst_ready = 1'b1;
            #1;
            if (o_inst_valid === 1'b1) begin
                checks++;
                if (o_inst_pc !== e || o_inst !== mem_inst(e)) begin
                    errors++; $display("[TB] FAIL bp_deliver_%0d got %h/%h want %h/%h", n, o_inst_pc, o_inst, e, mem_inst(e));
                end
                e = e + 64'h4;
                n++;
            end
        end
        checks++;
        if (n != 8) begin
            errors++; $display("[TB] FAIL bp_timeout delivered %0d want 8", n);
        end
    endtask

    task automatic test_redirect();
        logic [63:0] inflight;
        bit got_first;
        do_reset();
        i_inst_ready = 1'b1;
        repeat (5) @(negedge i_clk);
        inflight      = req_log[req_log.size() - 1];
        i_redirect    = 1'b1;
        i_redirect_pc = 64'h100;
        #1;
        checks++;
        if (o_imem_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL redir_noreq got %b want 0", o_imem_valid);
        end
        @(negedge i_clk);
        i_redirect = 1'b0;
        #1;
        checks++;
        if (o_imem_valid !== 1'b1 || o_imem_addr !== 64'h100) begin
            errors++; $display("[TB] FAIL redir_next_req got %b/%h want 1/100", o_imem_valid, o_imem_addr);
        end
        got_first = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (o_inst_valid === 1'b1) begin
                if (!got_first) begin
                    checks++;
                    if (o_inst_pc !== 64'h100 || o_inst !== mem_inst(64'h100)) begin
                        errors++; $display("[TB] FAIL redir_first got %h/%h want 100/%h", o_inst_pc, o_inst, mem_inst(64'h100));
                    end
                    got_first = 1'b1;
                end
                checks++;
                if (o_inst_pc === inflight) begin
                    errors++; $display("[TB] FAIL redir_discard got pc %h want anything but %h", o_inst_pc, inflight);
                end
            end
            @(negedge i_clk); #1;
        end
        checks++;
        if (!got_first) begin
            errors++; $display("[TB] FAIL redir_timeout got no delivery want pc 100");
        end
    endtask

    task automatic test_redirect_handshake();
        do_reset();
        repeat (7) @(negedge i_clk);
        i_inst_ready  = 1'b1;
        i_redirect    = 1'b1;
        i_redirect_pc = 64'h200;
        #1;
        checks++;
        if (o_inst_valid !== 1'b1 || o_inst_pc !== 64'h0) begin
            errors++; $display("[TB] FAIL rh_handshake got %b/%h want 1/0", o_inst_valid, o_inst_pc);
        end
        @(negedge i_clk);
        i_redirect = 1'b0;
        #1;
        checks++;
        if (o_inst_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL rh_empty got %b/%h want 0", o_inst_valid, o_inst_pc);
        end
        checks++;
        if (o_imem_valid !== 1'b1 || o_imem_addr !== 64'h200) begin
            errors++; $display("[TB] FAIL rh_req got %b/%h want 1/200", o_imem_valid, o_imem_addr);
        end
        @(negedge i_clk); #1;
        checks++;
        if (o_inst_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL rh_empty2 got %b/%h want 0", o_inst_valid, o_inst_pc);
        end
        @(negedge i_clk); #1;
        checks++;
        if (o_inst_valid !== 1'b1 || o_inst_pc !== 64'h200 || o_inst !== mem_inst(64'h200)) begin
            errors++; $display("[TB] FAIL rh_new_stream got %b/%h/%h want 1/200/%h", o_inst_valid, o_inst_pc, o_inst, mem_inst(64'h200));
        end
    endtask

    task automatic test_halt();
        logic [63:0] dpc [$];
        logic [31:0] dinst [$];
        logic [63:0] max_req;
        do_reset();
        halt_mode    = 1'b1;
        i_inst_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge i_clk); #1;
            if (o_inst_valid === 1'b1) begin
                dpc.push_back(o_inst_pc);
                dinst.push_back(o_inst);
            end
        end
        max_req = '0;
        foreach (req_log[i]) if (req_log[i] > max_req) max_req = req_log[i];
`ifdef IFU_HALT_DETECT_EN
        checks++;
        if (max_req > 64'h14) begin
            errors++; $display("[TB] FAIL halt_req_bound got %h want <= 14", max_req);
        end
        checks++;
        if (dpc.size() != 4) begin
            errors++; $display("[TB] FAIL halt_deliver_count got %0d want 4", dpc.size());
        end
        for (int i = 0; i < 4; i++) begin
            if (dpc.size() > i) begin
                checks++;
                if (dpc[i] !== 64'(4 * i) || dinst[i] !== mem_inst(64'(4 * i))) begin
                    errors++; $display("[TB] FAIL halt_deliver_%0d got %h/%h want %h/%h", i, dpc[i], dinst[i], 64'(4 * i), mem_inst(64'(4 * i)));
                end
            end
        end
        checks++;
        if (o_halted !== 1'b1) begin
            errors++; $display("[TB] FAIL halt_flag got %b want 1", o_halted);
        end
        @(negedge i_clk);
        i_redirect    = 1'b1;
        i_redirect_pc = 64'h40;
        @(negedge i_clk);
        i_redirect = 1'b0;
        #1;
        checks++;
        if (o_halted !== 1'b0 || o_imem_valid !== 1'b1 || o_imem_addr !== 64'h40) begin
            errors++; $display("[TB] FAIL halt_redirect got %b/%b/%h want 0/1/40", o_halted, o_imem_valid, o_imem_addr);
        end
`else
        begin
            int idx;
            idx = -1;
            foreach (dpc[i]) if (idx < 0 && dpc[i] === 64'h10) idx = i;
            checks++;
            if (idx < 0) begin
                errors++; $display("[TB] FAIL nohalt_deliver got no pc 10 want pc 10 inst ffffffff (max req %h)", max_req);
            end else begin
                checks++;
                if (dinst[idx] !== 32'hFFFF_FFFF) begin
                    errors++; $display("[TB] FAIL nohalt_inst got %h want ffffffff", dinst[idx]);
                end
            end
            checks++;
            if (o_halted !== 1'b0) begin
                errors++; $display("[TB] FAIL nohalt_flag got %b want 0", o_halted);
            end
        end
`endif
        halt_mode = 1'b0;
    endtask

    task automatic test_reset_midstream();
        bit got_first;
        do_reset();
        i_inst_ready = 1'b1;
        repeat (5) @(negedge i_clk);
        #8;
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_imem_valid !== 1'b0 || o_inst_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL mid_rst_valids got %b/%b want 0/0", o_imem_valid, o_inst_valid);
        end
        checks++;
        if (o_inst !== '0 || o_inst_pc !== '0 || o_halted !== 1'b0 || o_imem_addr !== RESET_PC) begin
            errors++; $display("[TB] FAIL mid_rst_outputs got %h/%h/%b/%h want 0/0/0/%h", o_inst, o_inst_pc, o_halted, o_imem_addr, RESET_PC);
        end
        i_rst_n = 1'b1;
        req_log.delete();
        @(negedge i_clk); #1;
        checks++;
        if (o_imem_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL mid_c0_noreq got %b want 0", o_imem_valid);
        end
        @(negedge i_clk); #1;
        checks++;
        if (o_imem_valid !== 1'b1 || o_imem_addr !== RESET_PC) begin
            errors++; $display("[TB] FAIL mid_first_req got %b/%h want 1/%h", o_imem_valid, o_imem_addr, RESET_PC);
        end
        got_first = 1'b0;
        for (int c = 0; c < 8 && !got_first; c++) begin
            @(negedge i_clk); #1;
            if (o_inst_valid === 1'b1) begin
                got_first = 1'b1;
                checks++;
                if (o_inst_pc !== RESET_PC || o_inst !== mem_inst(RESET_PC)) begin
                    errors++; $display("[TB] FAIL mid_first_inst got %h/%h want %h/%h", o_inst_pc, o_inst, RESET_PC, mem_inst(RESET_PC));
                end
            end
        end
        checks++;
        if (!got_first) begin
            errors++; $display("[TB] FAIL mid_timeout got no delivery want pc %h", RESET_PC);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_redirect_handshake();
        test_halt();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
